// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and index helpers for the round-robin stream mux
package mux_pkg;

    localparam int DEF_NUM_IN = 4;
    localparam int DEF_WIDTH  = 8;
    localparam int MAX_IN     = 16;

    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

    function automatic int onehot_to_idx(input logic [MAX_IN-1:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority search starting at rr_ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NUM_IN = DEF_NUM_IN,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  rr_ptr,
    output logic [NUM_IN-1:0] grant_onehot,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              any_grant
);

    logic [SEL_W-1:0]  pos;
    logic [MAX_IN-1:0] grant_ext;

    always_comb begin
        grant_onehot = '0;
        pos          = '0;
        // Walk from farthest to nearest so the request closest to rr_ptr wins.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            pos = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
            if (req[pos]) begin
                grant_onehot      = '0;
                grant_onehot[pos] = 1'b1;
            end
        end
    end

    always_comb begin
        grant_ext               = '0;
        grant_ext[NUM_IN-1:0]   = grant_onehot;
        grant_idx               = SEL_W'(onehot_to_idx(grant_ext));
        any_grant               = |req;
    end

endmodule

// File: rtl/mux_nx1_rr_stream.sv
// rtl/mux_nx1_rr_stream.sv - N:1 valid/ready stream mux with round-robin, packet lock and one output register
module mux_nx1_rr_stream
    import mux_pkg::*;
#(
    parameter  int NUM_IN = DEF_NUM_IN,
    parameter  int WIDTH  = DEF_WIDTH,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready,
    output logic                    locked
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  lock_ch;
    logic [SEL_W-1:0]  cand;
    logic [NUM_IN-1:0] arb_onehot;
    logic [SEL_W-1:0]  arb_idx;
    logic              arb_any;
    logic              load_en;
    logic              xfer;

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req          (in_valid),
        .rr_ptr       (rr_ptr),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx),
        .any_grant    (arb_any)
    );

    assign load_en = !out_valid || out_ready;
    assign cand    = locked ? lock_ch : arb_idx;
    // A held lock with its owner idle leaves everyone else waiting.
    assign xfer    = rst_n && load_en && (locked ? in_valid[lock_ch] : arb_any);

    always_comb begin
        in_ready = '0;
        if (rst_n && load_en) begin
            if (locked) in_ready[lock_ch] = in_valid[lock_ch];
            else        in_ready          = arb_onehot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            locked    <= 1'b0;
            lock_ch   <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[cand*WIDTH +: WIDTH];
                out_last  <= in_last[cand];
                out_sel   <= cand;
                if (in_last[cand]) begin
                    locked <= 1'b0;
                    rr_ptr <= SEL_W'(rr_next(int'(cand), NUM_IN));
                end else begin
                    locked  <= 1'b1;
                    lock_ch <= cand;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr_stream.sv
// tb/tb_mux_nx1_rr_stream.sv - table-driven scoreboard bench for mux_nx1_rr_stream
module tb_mux_nx1_rr_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_sel;
    logic        out_ready;
    logic        locked;

    mux_nx1_rr_stream #(.NUM_IN(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        int         grp;
        int         ch;
        logic [7:0] data;
        logic       last;
        int         gap;
        int         exp_sel;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    beat_t chbuf [4][32];
    int    head  [4];
    int    tail  [4];
    int    hold  [4];
    exp_t  sb [$];
    vec_t  vt [25];
    logic [3:0] fire;
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_x  = -1;
    int last_x   = -1;
    int bubbles  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        for (int c = 0; c < 4; c++) begin
            if (head[c] < tail[c] && hold[c] == 0) begin
                in_valid[c]         = 1'b1;
                in_data[c*8 +: 8]   = chbuf[c][head[c]].data;
                in_last[c]          = chbuf[c][head[c]].last;
            end
        end
    endtask

    task automatic push_beat(input int ch, input logic [7:0] d, input logic l, input int gap);
        chbuf[ch][tail[ch]] = '{d, l, gap};
        tail[ch]++;
    endtask

    task automatic load_group(input int g);
        for (int i = 0; i < 25; i++) begin
            if (vt[i].grp == g) begin
                push_beat(vt[i].ch, vt[i].data, vt[i].last, vt[i].gap);
                sb.push_back('{2'(vt[i].exp_sel), vt[i].exp_data, vt[i].exp_last});
            end
        end
    endtask

    // One clock: observe at the falling edge, update producers just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        fire = in_valid & in_ready;
        if (!rst_n) begin
            chk("ready_in_reset", 32'(in_ready), 32'd0);
        end else begin
            chk("ready_onehot", 32'($countones(in_ready) <= 1), 32'd1);
            if (locked) chk("lock_hole_grant", 32'(in_ready & ~(4'b0001 << out_sel)), 32'd0);
            if (out_valid && !out_ready) chk("ready_in_stall", 32'(in_ready), 32'd0);
            if (locked && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_sel",  32'(out_sel),  32'(e.sel));
                    chk("beat_data", 32'(out_data), 32'(e.data));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                    chk("beat_lock", 32'(locked),   32'(!e.last));
                end
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (hold[c] > 0) hold[c]--;
            if (fire[c]) begin
                hold[c] = chbuf[c][head[c]].gap;
                head[c]++;
            end
        end
        drive();
        cyc++;
    endtask

    task automatic run_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic flush_channels();
        for (int c = 0; c < 4; c++) begin
            head[c] = 0;
            tail[c] = 0;
            hold[c] = 0;
        end
        sb.delete();
    endtask

    initial begin
        // grp, ch, data, last, gap | exp_sel, exp_data, exp_last
        vt[0]  = '{1, 0, 8'h10, 1'b1, 0, 0, 8'h10, 1'b1};
        vt[1]  = '{1, 1, 8'h11, 1'b1, 0, 1, 8'h11, 1'b1};
        vt[2]  = '{1, 2, 8'h12, 1'b1, 0, 2, 8'h12, 1'b1};
        vt[3]  = '{1, 3, 8'h13, 1'b1, 0, 3, 8'h13, 1'b1};
        vt[4]  = '{1, 0, 8'h10, 1'b1, 0, 0, 8'h10, 1'b1};
        vt[5]  = '{1, 1, 8'h11, 1'b1, 0, 1, 8'h11, 1'b1};
        vt[6]  = '{1, 2, 8'h12, 1'b1, 0, 2, 8'h12, 1'b1};
        vt[7]  = '{1, 3, 8'h13, 1'b1, 0, 3, 8'h13, 1'b1};
        vt[8]  = '{2, 0, 8'h20, 1'b1, 0, 0, 8'h20, 1'b1};
        vt[9]  = '{2, 0, 8'h21, 1'b1, 0, 1, 8'hA0, 1'b0};
        vt[10] = '{2, 1, 8'hA0, 1'b0, 0, 1, 8'hA1, 1'b0};
        vt[11] = '{2, 1, 8'hA1, 1'b0, 0, 1, 8'hA2, 1'b1};
        vt[12] = '{2, 1, 8'hA2, 1'b1, 0, 2, 8'h22, 1'b1};
        vt[13] = '{2, 2, 8'h22, 1'b1, 0, 0, 8'h21, 1'b1};
        vt[14] = '{3, 3, 8'h30, 1'b0, 2, 3, 8'h30, 1'b0};
        vt[15] = '{3, 3, 8'h31, 1'b1, 0, 3, 8'h31, 1'b1};
        vt[16] = '{3, 0, 8'h40, 1'b1, 0, 0, 8'h40, 1'b1};
        vt[17] = '{4, 2, 8'h50, 1'b1, 0, 2, 8'h50, 1'b1};
        vt[18] = '{4, 2, 8'h51, 1'b1, 0, 2, 8'h51, 1'b1};
        vt[19] = '{5, 3, 8'h60, 1'b1, 0, 3, 8'h60, 1'b1};
        vt[20] = '{5, 3, 8'h62, 1'b1, 0, 0, 8'h61, 1'b1};
        vt[21] = '{5, 0, 8'h61, 1'b1, 0, 3, 8'h62, 1'b1};
        vt[22] = '{6, 1, 8'h91, 1'b1, 0, 0, 8'h90, 1'b1};
        vt[23] = '{6, 2, 8'h92, 1'b1, 0, 1, 8'h91, 1'b1};
        vt[24] = '{6, 0, 8'h90, 1'b1, 0, 2, 8'h92, 1'b1};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        fire      = '0;
        flush_channels();
        drive();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // All channels streaming single-beat packets: strict rotation at full rate.
        load_group(1);
        drive();
        first_x = -1;
        run_drain("rr_cycle", 40);
        chk("rr_throughput", 32'(last_x - first_x), 32'd7);

        // Multi-beat packet on channel 1 holds the grant against 0 and 2.
        load_group(2);
        drive();
        run_drain("pkt_lock", 40);

        // Channel 3 pauses mid-packet; channel 0 must not sneak in.
        bubbles = 0;
        load_group(3);
        drive();
        run_drain("lock_hole", 40);
        chk("lock_hole_bubbles", 32'(bubbles), 32'd2);

        // Backpressure: the output register freezes, then drains and reloads together.
        out_ready = 1'b0;
        load_group(4);
        drive();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'h50);
            chk("stall_sel",   32'(out_sel),   32'd2);
            chk("stall_last",  32'(out_last),  32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 32'(in_ready),  32'b0100);
        chk("release_valid", 32'(out_valid), 32'd1);
        run_drain("stall", 40);

        // Pointer wraps from 3 back to 0 with only channels 0 and 3 requesting.
        load_group(5);
        drive();
        run_drain("wrap", 40);

        // Asynchronous reset in the middle of a channel-2 packet.
        push_beat(2, 8'h70, 1'b0, 0);
        push_beat(2, 8'h71, 1'b0, 0);
        sb.push_back('{2'd2, 8'h70, 1'b0});
        drive();
        run_drain("pre_reset", 40);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_locked",    32'(locked),    32'd0);
        chk("mid_rst_out_sel",   32'(out_sel),   32'd0);
        flush_channels();
        load_group(6);
        drive();
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        #2 rst_n = 1'b1;
        run_drain("post_reset", 40);

        repeat (4) step();
        chk("no_stray_beats", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
